// File: rtl/arb_pkg.sv
// Shared types for the round-robin / priority arbiter.
package arb_pkg;

  // Arbitration mode as seen on mode_i; the reserved encoding arbitrates like LSB.
  typedef enum logic [1:0] {
    ARB_LSB  = 2'd0,
    ARB_MSB  = 2'd1,
    ARB_RR   = 2'd2,
    ARB_RSVD = 2'd3
  } arb_mode_e;

  // Controller state: IDLE = no grant outstanding, BUSY = one channel holds the grant.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/pri_pick.sv
// Rotating priority picker: first set bit of req_i at or above start_i, wrapping.
module pri_pick #(
  parameter int WID = 4
) (
  input  logic [WID-1:0]         req_i,
  input  logic [$clog2(WID)-1:0] start_i,
  output logic [WID-1:0]         gnt_o,
  output logic [$clog2(WID)-1:0] idx_o,
  output logic                   any_o
);

  localparam int IW = $clog2(WID);

  // Walk WID positions starting at start_i; the first requester wins.
  always_comb begin
    int            j;
    logic [IW-1:0] j_idx;
    logic          found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    j_idx = '0;
    for (int k = 0; k < WID; k++) begin
      j = int'(start_i) + k;
      if (j >= WID) j = j - WID;
      j_idx = IW'(j);
      if (!found && req_i[j_idx]) begin
        found        = 1'b1;
        gnt_o[j_idx] = 1'b1;
        idx_o        = j_idx;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/rr_pri_arbiter.sv
// Grant-holding arbiter with LSB / MSB fixed priority and round-robin modes,
// release on done, request drop or hold timeout, back-to-back re-arbitration.
module rr_pri_arbiter
  import arb_pkg::*;
#(
  parameter int WID      = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [WID-1:0]         req_i,
  input  logic [1:0]             mode_i,
  input  logic                   done_i,
  output logic [WID-1:0]         gnt_o,
  output logic [$clog2(WID)-1:0] gnt_id_o,
  output logic                   gnt_vld_o
);

  localparam int IW = $clog2(WID);
  // A zero-width counter is not legal; with no timeout a 1-bit counter just saturates.
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  arb_state_e    state_q, state_d;
  logic [WID-1:0] gnt_q, gnt_d;
  logic [IW-1:0]  id_q, id_d;
  logic           vld_q, vld_d;
  logic [IW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [HW-1:0]  hold_q, hold_d;

  arb_mode_e      mode;
  logic           msb_mode;
  logic [WID-1:0] arb_req, pick_req, pick_gnt, win_gnt;
  logic [IW-1:0]  pick_start, pick_idx, win_idx;
  logic           pick_any;
  logic           timeout, release_ev, arbitrate;

  assign mode     = arb_mode_e'(mode_i);
  assign msb_mode = (mode == ARB_MSB);

  // The current grantee is never a candidate in its own release cycle.
  assign arb_req    = (state_q == ST_BUSY) ? (req_i & ~gnt_q) : req_i;
  assign pick_start = (mode == ARB_RR) ? rr_ptr_q : '0;

  // MSB-first is LSB-first on a bit-reversed vector, so one picker serves all modes.
  for (genvar i = 0; i < WID; i++) begin : g_rev
    assign pick_req[i] = msb_mode ? arb_req[WID-1-i]  : arb_req[i];
    assign win_gnt[i]  = msb_mode ? pick_gnt[WID-1-i] : pick_gnt[i];
  end

  pri_pick #(.WID(WID)) u_pick (
    .req_i   (pick_req),
    .start_i (pick_start),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  assign win_idx = msb_mode ? (IW'(WID - 1) - pick_idx) : pick_idx;

  assign timeout    = (MAX_HOLD != 0) && (hold_q >= HW'(MAX_HOLD));
  // done and timeout in the same cycle collapse into one release.
  assign release_ev = done_i | ~req_i[id_q] | timeout;
  assign arbitrate  = (state_q == ST_IDLE) | release_ev;

  // Next-state: arbitrate when idle or releasing, otherwise hold and count.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    id_d     = id_q;
    vld_d    = vld_q;
    rr_ptr_d = rr_ptr_q;
    hold_d   = hold_q;
    if (arbitrate) begin
      if (pick_any) begin
        state_d  = ST_BUSY;
        gnt_d    = win_gnt;
        id_d     = win_idx;
        vld_d    = 1'b1;
        hold_d   = HW'(1);
        rr_ptr_d = (win_idx == IW'(WID - 1)) ? '0 : win_idx + 1'b1;
      end else begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        id_d    = '0;
        vld_d   = 1'b0;
        hold_d  = '0;
      end
    end else begin
      hold_d = (hold_q == '1) ? hold_q : hold_q + 1'b1;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      id_q     <= '0;
      vld_q    <= 1'b0;
      rr_ptr_q <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      id_q     <= id_d;
      vld_q    <= vld_d;
      rr_ptr_q <= rr_ptr_d;
      hold_q   <= hold_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign gnt_id_o  = id_q;
  assign gnt_vld_o = vld_q;

endmodule

// File: tb/tb_rr_pri_arbiter.sv
// Directed scoreboard bench for rr_pri_arbiter (WID=4, MAX_HOLD=4).
module tb_rr_pri_arbiter;

  localparam int WID = 4;
  localparam int IW  = 2;

  logic           clk_i = 1'b0;
  logic           rst_i = 1'b1;
  logic [WID-1:0] req_i = '0;
  logic [1:0]     mode_i = 2'd0;
  logic           done_i = 1'b0;
  logic [WID-1:0] gnt_o;
  logic [IW-1:0]  gnt_id_o;
  logic           gnt_vld_o;

  int errors = 0;
  int checks = 0;
  logic [WID-1:0] exp_q[$];

  always #5 clk_i = ~clk_i;

  rr_pri_arbiter #(.WID(WID), .MAX_HOLD(4)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_i),
    .mode_i    (mode_i),
    .done_i    (done_i),
    .gnt_o     (gnt_o),
    .gnt_id_o  (gnt_id_o),
    .gnt_vld_o (gnt_vld_o)
  );

  function automatic logic [IW-1:0] idx_of(input logic [WID-1:0] g);
    logic [IW-1:0] r;
    r = '0;
    for (int i = 0; i < WID; i++) if (g[i]) r = IW'(i);
    return r;
  endfunction

  // Drive one cycle of inputs and push the grant expected after the next edge.
  task automatic step(input logic rst, input logic [1:0] mode,
                      input logic [WID-1:0] req, input logic done,
                      input logic [WID-1:0] exp_gnt);
    @(negedge clk_i);
    rst_i  = rst;
    mode_i = mode;
    req_i  = req;
    done_i = done;
    exp_q.push_back(exp_gnt);
  endtask

  // Monitor: pop one expectation per edge and compare all three outputs.
  always @(posedge clk_i) begin
    logic [WID-1:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (gnt_o !== e) begin
        errors++;
        $display("FAIL gnt t=%0t got=%b exp=%b", $time, gnt_o, e);
      end
      checks++;
      if (gnt_id_o !== idx_of(e)) begin
        errors++;
        $display("FAIL gnt_id t=%0t got=%0d exp=%0d", $time, gnt_id_o, idx_of(e));
      end
      checks++;
      if (gnt_vld_o !== (e != '0)) begin
        errors++;
        $display("FAIL gnt_vld t=%0t got=%b exp=%b", $time, gnt_vld_o, (e != '0));
      end
      checks++;
      if ($countones(gnt_o) > 1) begin
        errors++;
        $display("FAIL onehot t=%0t got=%b exp=at most one bit", $time, gnt_o);
      end
    end
  end

  initial begin
    // reset state
    step(1, 0, 4'b0000, 0, 4'b0000);
    step(1, 0, 4'b1111, 1, 4'b0000);
    // LSB first, first cycle after reset; done releases to remaining requester
    step(0, 0, 4'b1010, 0, 4'b0010);
    step(0, 0, 4'b1010, 1, 4'b1000);
    step(0, 0, 4'b0000, 0, 4'b0000);
    // MSB: hold two cycles, done in cycle 3, back-to-back to 0010
    step(0, 1, 4'b1010, 0, 4'b1000);
    step(0, 1, 4'b1010, 0, 4'b1000);
    step(0, 1, 4'b1010, 1, 4'b0010);
    step(0, 1, 4'b0000, 0, 4'b0000);
    // RR from rr_ptr=2 grants 0100, then reset while busy
    step(0, 2, 4'b0100, 0, 4'b0100);
    step(1, 2, 4'b1111, 0, 4'b0000);
    // RR after reset starts at 0 (done in IDLE ignored), then rotates
    step(0, 2, 4'b1111, 1, 4'b0001);
    step(0, 2, 4'b1111, 1, 4'b0010);
    step(0, 2, 4'b1111, 1, 4'b0100);
    step(0, 2, 4'b1111, 1, 4'b1000);
    step(0, 2, 4'b1111, 1, 4'b0001);
    step(0, 2, 4'b0000, 0, 4'b0000);
    // timeout with lone requester: 4 cycles, one idle gap, re-grant
    step(0, 0, 4'b0001, 0, 4'b0001);
    step(0, 0, 4'b0001, 0, 4'b0001);
    step(0, 0, 4'b0001, 0, 4'b0001);
    step(0, 0, 4'b0001, 0, 4'b0001);
    step(0, 0, 4'b0001, 0, 4'b0000);
    step(0, 0, 4'b0001, 0, 4'b0001);
    step(0, 0, 4'b0000, 0, 4'b0000);
    // grantee drops request, index 3 pending
    step(0, 0, 4'b1001, 0, 4'b0001);
    step(0, 0, 4'b1000, 0, 4'b1000);
    step(0, 0, 4'b0000, 0, 4'b0000);
    // mode change mid-grant ignored; done + timeout together is one release
    step(0, 0, 4'b0011, 0, 4'b0001);
    step(0, 1, 4'b0011, 0, 4'b0001);
    step(0, 1, 4'b0011, 0, 4'b0001);
    step(0, 1, 4'b0011, 0, 4'b0001);
    step(0, 1, 4'b0011, 1, 4'b0010);
    step(0, 1, 4'b0011, 0, 4'b0010);
    step(0, 1, 4'b0000, 0, 4'b0000);
    // reserved mode arbitrates like LSB
    step(0, 3, 4'b0110, 0, 4'b0010);
    step(0, 3, 4'b0000, 0, 4'b0000);
    // drain the scoreboard with a bounded wait
    begin
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 20) begin
        @(posedge clk_i);
        n++;
      end
      #2;
      if (exp_q.size() > 0) begin
        errors++;
        $display("FAIL drain got=%0d pending exp=0", exp_q.size());
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
